// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Define MULDIV_DIVZERO_FLAG_EN to add the sticky div_zero output.
//
// state | meaning
// IDLE  | waiting for an op; MTHI/MTLO write HI/LO directly
// RUN   | one shift-add or restoring-divide iteration per clock
// FIX   | sign correction and HI/LO write-back
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIVZERO_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               is_div, neg_q, neg_r;

    logic               sgn_op, sa, sb, accept_md;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign sgn_op    = ~op[0];
    assign sa        = sgn_op & rs_val[WIDTH-1];
    assign sb        = sgn_op & rt_val[WIDTH-1];
    assign mag_a     = sa ? -rs_val : rs_val;
    assign mag_b     = sb ? -rt_val : rt_val;
    assign accept_md = (state == IDLE) && start && !op[2];

    // Multiply: acc = {partial sum, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend/quotient bits}.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opb};

    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: if (accept_md) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (flush)                          state_nxt = IDLE;
                else if (count == CW'(WIDTH - 1))   state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_md) begin
                        count  <= '0;
                        is_div <= op[1];
                        neg_r  <= sa;
                        if (op[1]) begin
                            acc   <= {{WIDTH{1'b0}}, mag_a};
                            opb   <= mag_b;
                            // A zero divisor must leave the all-ones quotient uncorrected.
                            neg_q <= (sa ^ sb) & (rt_val != '0);
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, mag_b};
                            opb   <= mag_a;
                            neg_q <= sa ^ sb;
                        end
                    end else if (start && op == 3'd4) begin
                        hi <= rs_val;
                    end else if (start && op == 3'd5) begin
                        lo <= rs_val;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        count <= count + 1'b1;
                        if (is_div)
                            acc <= {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                                    acc[WIDTH-2:0], ~div_diff[WIDTH]};
                        else
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (!flush) begin
                        done <= 1'b1;
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MULDIV_DIVZERO_FLAG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            div_zero <= 1'b0;
        else if (accept_md && op[1])
            div_zero <= 1'b0;
        else if (state == FIX && !flush && is_div && opb == '0)
            div_zero <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: vector table, flush/reset/MTHI sequences, random ops vs model.
module tb_mips_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, flush;
    logic [2:0]   op;
    logic [W-1:0] rs_val, rt_val;
    logic         busy, done;
    logic [W-1:0] hi, lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic         div_zero;
    logic         model_dz = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MULDIV_DIVZERO_FLAG_EN
        , .div_zero(div_zero)
`endif
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, hi, lo;
        string        name;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb, q, r;
        logic [63:0]  ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            3'd0: return sa * sb;
            3'd1: return ua * ub;
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (o == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string name, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int lat;
        bit busy_ok;
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, lat, W + 1);
        chk({name, " busy"}, {busy_ok, busy}, 2'b10);
        chk({name, " hi"}, hi, ehi);
        chk({name, " lo"}, lo, elo);
        @(negedge clk);
        chk({name, " done_pulse"}, done, 1'b0);
`ifdef MULDIV_DIVZERO_FLAG_EN
        if (o[1]) model_dz = (b == 0);
        chk({name, " div_zero"}, div_zero, model_dz);
`endif
    endtask

    task automatic watch_no_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({name, " no_done"}, seen, 1'b0);
    endtask

    vec_t vecs[10];

    initial begin
        logic [63:0] exp;
        logic [2:0]  ro;
        logic [W-1:0] ra, rb;

        vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m3x7"};
        vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, "multu_max_x2"};
        vecs[2] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        "divu_100_7"};
        vecs[3] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2"};
        vecs[4] = '{3'd2, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, "div_by_zero"};
        vecs[5] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minneg_sq"};
        vecs[6] = '{3'd3, 32'd8,         32'd2,         32'd0,         32'd4,         "divu_8_2"};
        vecs[7] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_overflow"};
        vecs[8] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_7_m2"};
        vecs[9] = '{3'd3, 32'h8000_0000, 32'd0,         32'h8000_0000, 32'hFFFF_FFFF, "divu_by_zero"};

        reset = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd6; rs_val = '0; rt_val = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].name, vecs[i].hi, vecs[i].lo);

        // MTHI / MTLO in IDLE
        @(negedge clk);
        start = 1'b1; op = 3'd4; rs_val = 32'hAAAA_5555;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        chk("mthi hi", hi, 32'hAAAA_5555);
        chk("mthi busy", {busy, done}, 2'b00);
        start = 1'b1; op = 3'd5; rs_val = 32'h1111_1111;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        chk("mtlo lo", lo, 32'h1111_1111);
        chk("mtlo hi kept", hi, 32'hAAAA_5555);

        // flush a DIVU in flight
        start = 1'b1; op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        repeat (9) @(negedge clk);
        chk("flush pre busy", busy, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", busy, 1'b0);
`ifdef MULDIV_DIVZERO_FLAG_EN
        model_dz = 1'b0;
        chk("flush div_zero", div_zero, model_dz);
`endif
        watch_no_done("flush");
        chk("flush hi", hi, 32'hAAAA_5555);
        chk("flush lo", lo, 32'h1111_1111);

        // MTLO issued while busy is ignored
        start = 1'b1; op = 3'd1; rs_val = 32'd3; rt_val = 32'd5;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        repeat (3) @(negedge clk);
        start = 1'b1; op = 3'd5; rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        chk("mtlo_busy lo", lo, 32'h1111_1111);
        chk("mtlo_busy busy", busy, 1'b1);
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        chk("mtlo_busy result", {hi, lo}, 64'd15);

        // reset mid-RUN of a MULT
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs_val = 32'd5; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midreset busy", busy, 1'b0);
        chk("midreset done", done, 1'b0);
        chk("midreset hilo", {hi, lo}, 64'd0);
`ifdef MULDIV_DIVZERO_FLAG_EN
        model_dz = 1'b0;
        chk("midreset div_zero", div_zero, model_dz);
`endif
        @(negedge clk);
        reset = 1'b1;
        watch_no_done("midreset");
        chk("midreset hilo after", {hi, lo}, 64'd0);

        // random ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            exp = ref_model(ro, ra, rb);
            run_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro), exp[63:32], exp[31:0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers.
- Sits beside the EX stage of the MIPS core; consumed by the pipeline.
- EX issues MULT/MULTU/DIV/DIVU/MTHI/MTLO here.
- The hazard logic stalls on `busy`; MFHI/MFLO read `hi`/`lo` directly.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  issue-op strobe from EX.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 = no-op.
- rs_val  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- rt_val  input  WIDTH  multiplier / divisor.
- flush  input  1  cancel in-flight op (branch/exception squash).
- busy  output  1  op in flight; pipeline stalls MFHI/MFLO and new muldiv ops.
- done  output  1  one-cycle pulse when HI/LO are updated by MULT/DIV.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, hi=0, lo=0; internal counters and accumulators cleared. Reset mid-operation aborts with no HI/LO update.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 with op 0-3: latch operands and op, count=0, go to RUN.
  - For signed ops, operands are converted to magnitudes and result sign flags are recorded (product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa).
  - start=1 with op 4 or 5: write rs_val into hi or lo at that edge. No busy, no done, stay IDLE.
  - op 6/7: ignored.
- RUN:
  - One iteration per clock, count increments.
  - Multiply: shift-add, WIDTH-bit multiplier, 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - After iteration WIDTH (count==WIDTH-1), go to FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Write hi/lo: multiply gives hi=upper half, lo=lower half; divide gives lo=quotient, hi=remainder.
  - done=1 for exactly this following cycle; go to IDLE.
- Latency: start sampled at edge 0 → busy=1 after edge 0 → hi/lo valid and done=1 after edge WIDTH+1, busy=0 after the same edge. busy never overlaps done.
- start while busy=1: ignored, including MTHI/MTLO; the pipeline must not issue it.
- flush=1 while busy: next edge → IDLE, busy=0, done=0, hi/lo unchanged. flush in IDLE has no effect. flush has priority over start at the same edge.
- Divide by zero (rt_val=0), DIV and DIVU alike: full latency, hi=rs_val (original, unsigned view), lo=all ones. No trap.
- Signed overflow (DIV most-negative / -1): lo=most-negative, hi=0; falls out of the magnitude path, no special case.
- hi/lo change only at reset, at the FIX edge, or on an accepted MTHI/MTLO.

Optional Feature:
- Macro: MULDIV_DIVZERO_FLAG_EN.
- Defined:
  - Adds output `div_zero` (1 bit), reset 0.
  - Set at the FIX edge of any DIV/DIVU with divisor 0; sticky until reset or the next accepted DIV/DIVU start, which clears it at that start edge.
  - MULT and MTHI/MTLO leave it unchanged.
- Undefined: port absent; divide-by-zero result rules unchanged.

Test Plan:
- Reset: assert reset=0 mid-RUN of a MULT → busy=0, done=0, hi=lo=0 immediately; release, no done pulse follows.
- MULT rs=0xFFFFFFFD (-3), rt=7 → done exactly 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for cycles 1-32.
- MULTU rs=0xFFFFFFFF, rt=2 → hi=0x00000001, lo=0xFFFFFFFE.
- DIVU 100/7 → lo=14, hi=2. DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x12345678/0 → hi=0x12345678, lo=0xFFFFFFFF. With MULDIV_DIVZERO_FLAG_EN, div_zero=1 until the next DIVU 8/2 start.
- MTHI 0xAAAA5555 in IDLE → hi updated next edge, no busy. Start DIVU, flush at cycle 10 → busy=0 next cycle, no done, hi still 0xAAAA5555. MTLO issued while busy → lo unchanged.
